// File: rtl/image_pattern_pkg.sv
// Shared types for the AXI4-Stream video test-pattern source.
// Pattern selector, FSM state encoding and frame counter width.
package image_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_HGRAD = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/image_pattern_pixel.sv
// One pixel lane of the test-pattern source.
// Pure combinational value for column px under the latched pattern.
module image_pattern_pixel
  import image_pattern_pkg::*;
#(
  parameter int PIXEL_BITWIDTH = 8,
  parameter int IMAGE_W        = 300,
  parameter int CHECK_LOG2     = 4,
  parameter int CNT_W          = 13
) (
  input  logic [CNT_W-1:0]          px,
  input  pattern_t                  pat,
  input  logic [PIXEL_BITWIDTH-1:0] solid,
  input  logic                      parity,
  output logic [PIXEL_BITWIDTH-1:0] value
);

  localparam int PB = PIXEL_BITWIDTH;

  logic [6:0]    ge;
  logic [2:0]    bar;
  logic [PB-1:0] grad;
  logic          check;

  // bar index is the number of thresholds px has reached,
  // threshold k being ceil(k*IMAGE_W/8), so no divider is needed
  for (genvar k = 1; k < 8; k++) begin : g_thr
    localparam int THR = (k * IMAGE_W + 7) / 8;
    assign ge[k-1] = px >= CNT_W'(THR);
  end

  if (PB <= CNT_W) begin : g_grad_narrow
    assign grad = px[PB-1:0];
  end else begin : g_grad_wide
    assign grad = {{(PB-CNT_W){1'b0}}, px};
  end

  assign check = px[CHECK_LOG2] ^ parity;

  // count reached thresholds into the bar index
  always_comb begin
    bar = 3'd0;
    for (int k = 0; k < 7; k++) begin
      bar = bar + {2'b00, ge[k]};
    end
  end

  // select the lane value for the active pattern
  always_comb begin
    value = '0;
    unique case (pat)
      PAT_SOLID: value = solid;
      PAT_HGRAD: value = grad;
      PAT_BARS:  value = {bar, {(PB-3){bar[0]}}};
      PAT_CHECK: value = {PB{check}};
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/image_pattern_gen.sv
// AXI4-Stream video test-pattern source with blanking,
// backpressure hold and frame-boundary start/stop control.
module image_pattern_gen
  import image_pattern_pkg::*;
#(
  parameter int PIXEL_BITWIDTH = 8,
  parameter int PIXEL_NUM      = 1,
  parameter int IMAGE_W        = 300,
  parameter int IMAGE_H        = 300,
  parameter int H_BLANK        = 200,
  parameter int V_BLANK        = 100,
  parameter int CHECK_LOG2     = 4,
  parameter int CNT_W          = 13
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [1:0]                          pattern_sel,
  input  logic [PIXEL_BITWIDTH-1:0]           solid_value,
  input  logic                                m_axis_ready,
  output logic                                m_axis_valid,
  output logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0] m_axis_data,
  output logic                                m_axis_sof,
  output logic                                m_axis_eol,
  output logic                                m_axis_eof,
  output logic [FRAME_CNT_W-1:0]              frame_cnt
);

  localparam int PB = PIXEL_BITWIDTH;
  localparam int DW = PB * PIXEL_NUM;

  localparam logic [CNT_W-1:0] STEP   = CNT_W'(PIXEL_NUM);
  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(IMAGE_W - PIXEL_NUM);
  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(IMAGE_H - 1);
  localparam logic [CNT_W-1:0] HB_END = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_END = CNT_W'(V_BLANK - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic                    start;
  logic [CNT_W-1:0]        x_q;
  logic [CNT_W-1:0]        y_q;
  logic [CNT_W-1:0]        bcnt_q;
  logic [FRAME_CNT_W-1:0]  frame_q;
  pattern_t                pat_q;
  logic [PB-1:0]           solid_q;

  logic                    valid_q;
  logic [DW-1:0]           data_q;
  logic                    sof_q;
  logic                    eol_q;
  logic                    eof_q;

  logic                    hs;
  logic                    last_x;
  logic                    last_y;
  logic                    hb_done;
  logic                    vb_done;
  logic                    load;
  logic [CNT_W-1:0]        load_x;
  logic                    parity;
  logic [DW-1:0]           data_next;

  assign hs      = valid_q && m_axis_ready;
  assign last_x  = x_q == LAST_X;
  assign last_y  = y_q == LAST_Y;
  assign hb_done = bcnt_q == HB_END;
  assign vb_done = bcnt_q == VB_END;

  // x_q is the column of the beat on the bus; when it is taken
  // the next beat is loaded in the same cycle so a line has no bubbles
  assign load_x = valid_q ? x_q + STEP : x_q;
  assign load   = (state_q == ST_ACTIVE)
               && (!valid_q || (hs && !last_x));
  assign parity = y_q[CHECK_LOG2] ^ frame_q[0];

  for (genvar i = 0; i < PIXEL_NUM; i++) begin : g_lane
    logic [CNT_W-1:0] px;
    assign px = load_x + CNT_W'(i);
    image_pattern_pixel #(
      .PIXEL_BITWIDTH (PB),
      .IMAGE_W        (IMAGE_W),
      .CHECK_LOG2     (CHECK_LOG2),
      .CNT_W          (CNT_W)
    ) u_pix (
      .px     (px),
      .pat    (pat_q),
      .solid  (solid_q),
      .parity (parity),
      .value  (data_next[i*PB +: PB])
    );
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state; enable is only looked at in IDLE and at the end of VBLANK
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACTIVE;
          start   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (hs && last_x) begin
          state_d = last_y ? ST_VBLANK : ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (hb_done) state_d = ST_ACTIVE;
      end
      ST_VBLANK: begin
        if (vb_done) begin
          if (enable) begin
            state_d = ST_ACTIVE;
            start   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // position, blanking and frame counters plus per-frame control latch;
  // blank counters run on cycles, pixel counters only on handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      frame_q <= '0;
      pat_q   <= PAT_SOLID;
      solid_q <= '0;
    end else begin
      unique case (state_q)
        ST_ACTIVE: begin
          if (hs && !last_x) x_q <= x_q + STEP;
        end
        ST_HBLANK: begin
          if (hb_done) begin
            bcnt_q <= '0;
            x_q    <= '0;
            y_q    <= y_q + CNT_W'(1);
          end else begin
            bcnt_q <= bcnt_q + CNT_W'(1);
          end
        end
        ST_VBLANK: begin
          if (vb_done) begin
            bcnt_q  <= '0;
            frame_q <= frame_q + FRAME_CNT_W'(1);
          end else begin
            bcnt_q <= bcnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (start) begin
        x_q     <= '0;
        y_q     <= '0;
        pat_q   <= pattern_t'(pattern_sel);
        solid_q <= solid_value;
      end
    end
  end

  // output beat register: load a fresh beat, hold under
  // backpressure, drop valid once the last beat of a line is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_next;
      sof_q   <= (load_x == '0) && (y_q == '0);
      eol_q   <= load_x == LAST_X;
      eof_q   <= (load_x == LAST_X) && last_y;
    end else if (hs) begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end
  end

  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign m_axis_sof   = sof_q;
  assign m_axis_eol   = eol_q;
  assign m_axis_eof   = eof_q;
  assign frame_cnt    = frame_q;

endmodule
